// File: rtl/axil_multi_adder.sv
// AXI4-Lite slave with NUM_CH add/sub channels (OPA, OPB, CTRL, RESULT) and sticky carry/borrow status.
// Independent registered write and read handshakes; the result is committed on the CTRL write handshake edge.
module axil_multi_adder #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    s1_axi_aclk,
    input  logic                    s1_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready
);
    localparam int          NB      = DATA_WIDTH / 8;
    localparam logic [31:0] ID_WORD = {16'hADD2, 16'(NUM_CH)};

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    logic awready_q, awready_d, bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [NUM_CH-1:0][1:0]            ctrl_q, ctrl_d;
    logic [NUM_CH-1:0]                 status_q, status_d, sts_set, sts_clr;

    logic [DATA_WIDTH-1:0] wmask, x, y, rd_val;
    logic [DATA_WIDTH:0]   sum;
    logic [3:0]            wch, rch;
    logic [1:0]            woff, roff;
    logic                  w_err, r_err;
    logic                  addr_lsb_unused;

    assign wch  = s1_axi_awaddr[7:4];
    assign woff = s1_axi_awaddr[3:2];
    assign rch  = s1_axi_araddr[7:4];
    assign roff = s1_axi_araddr[3:2];
    assign addr_lsb_unused = ^{s1_axi_awaddr[1:0], s1_axi_araddr[1:0]};

    always_comb begin
        for (int b = 0; b < NB; b++) wmask[8*b +: 8] = {8{s1_axi_wstrb[b]}};
    end

    always_comb begin : wr_path
        wstate_d  = wstate_q;
        awready_d = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        ctrl_d    = ctrl_q;
        res_d     = res_q;
        sts_set   = '0;
        sts_clr   = '0;
        w_err     = 1'b1;
        x         = '0;
        y         = '0;
        sum       = '0;
        case (wstate_q)
            W_IDLE: begin
                if (awready_q) begin
                    if (s1_axi_awvalid && s1_axi_wvalid) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (wch == 4'(i)) begin
                                w_err = 1'b0;
                                case (woff)
                                    2'd0: opa_d[i] = (opa_q[i] & ~wmask) | (s1_axi_wdata & wmask);
                                    2'd1: opb_d[i] = (opb_q[i] & ~wmask) | (s1_axi_wdata & wmask);
                                    2'd2: if (s1_axi_wstrb[0]) begin
                                        ctrl_d[i] = s1_axi_wdata[1:0];
                                        // GO acts on the mode bits carried by this very write
                                        if (s1_axi_wdata[2]) begin
                                            x   = s1_axi_wdata[1] ? res_q[i] : opa_q[i];
                                            y   = s1_axi_wdata[1] ? opa_q[i] : opb_q[i];
                                            sum = s1_axi_wdata[0] ? {1'b0, x} - {1'b0, y}
                                                                  : {1'b0, x} + {1'b0, y};
                                            res_d[i]   = sum[DATA_WIDTH-1:0];
                                            sts_set[i] = sum[DATA_WIDTH];
                                        end
                                    end
                                    default: w_err = 1'b1;
                                endcase
                            end
                        end
                        if (s1_axi_awaddr[7:2] == 6'h3C) begin
                            w_err   = 1'b0;
                            sts_clr = s1_axi_wdata[NUM_CH-1:0] & wmask[NUM_CH-1:0];
                        end
                        if (w_err) begin
                            opa_d = opa_q; opb_d = opb_q; ctrl_d = ctrl_q; res_d = res_q;
                        end
                        bvalid_d = 1'b1;
                        bresp_d  = w_err ? 2'b10 : 2'b00;
                        wstate_d = W_RESP;
                    end
                end else if (s1_axi_awvalid && s1_axi_wvalid) begin
                    awready_d = 1'b1;
                end
            end
            W_RESP: if (s1_axi_bready) begin
                bvalid_d = 1'b0;
                wstate_d = W_IDLE;
            end
        endcase
        // set beats clear on the same bit
        status_d = (status_q & ~sts_clr) | sts_set;
    end

    always_comb begin : rd_path
        rstate_d  = rstate_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_val    = '0;
        r_err     = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rch == 4'(i)) begin
                r_err = 1'b0;
                case (roff)
                    2'd0: rd_val = opa_q[i];
                    2'd1: rd_val = opb_q[i];
                    2'd2: rd_val = DATA_WIDTH'(ctrl_q[i]);
                    default: rd_val = res_q[i];
                endcase
            end
        end
        if (s1_axi_araddr[7:2] == 6'h3C) begin
            r_err  = 1'b0;
            rd_val = DATA_WIDTH'(status_q);
        end else if (s1_axi_araddr[7:2] == 6'h3D) begin
            r_err  = 1'b0;
            rd_val = DATA_WIDTH'(ID_WORD);
        end
        case (rstate_q)
            R_IDLE: begin
                if (arready_q) begin
                    if (s1_axi_arvalid) begin
                        rdata_d  = r_err ? '0 : rd_val;
                        rresp_d  = r_err ? 2'b10 : 2'b00;
                        rvalid_d = 1'b1;
                        rstate_d = R_DATA;
                    end
                end else if (s1_axi_arvalid) begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: if (s1_axi_rready) begin
                rvalid_d = 1'b0;
                rstate_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
        if (!s1_axi_aresetn) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            ctrl_q    <= '0;
            status_q  <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
        end
    end

    assign s1_axi_awready = awready_q;
    assign s1_axi_wready  = awready_q;
    assign s1_axi_bvalid  = bvalid_q;
    assign s1_axi_bresp   = bresp_q;
    assign s1_axi_arready = arready_q;
    assign s1_axi_rvalid  = rvalid_q;
    assign s1_axi_rdata   = rdata_q;
    assign s1_axi_rresp   = rresp_q;
endmodule

// File: tb/tb_axil_multi_adder.sv
// Bench for axil_multi_adder: per-scenario tasks, expected responses queued on issue and
// popped when the DUT responds.
module tb_axil_multi_adder;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    int checks = 0;
    int failures = 0;

    typedef struct packed {logic [DW-1:0] data; logic [1:0] resp;} exp_t;
    typedef struct packed {
        logic is_wr; logic [7:0] a; logic [31:0] d; logic [3:0] s; logic [31:0] ed; logic [1:0] er;
    } op_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    axil_multi_adder #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .s1_axi_aclk(clk), .s1_axi_aresetn(rst_n),
        .s1_axi_awaddr(awaddr), .s1_axi_awvalid(awvalid), .s1_axi_awready(awready),
        .s1_axi_wdata(wdata), .s1_axi_wstrb(wstrb), .s1_axi_wvalid(wvalid), .s1_axi_wready(wready),
        .s1_axi_bresp(bresp), .s1_axi_bvalid(bvalid), .s1_axi_bready(bready),
        .s1_axi_araddr(araddr), .s1_axi_arvalid(arvalid), .s1_axi_arready(arready),
        .s1_axi_rdata(rdata), .s1_axi_rresp(rresp), .s1_axi_rvalid(rvalid), .s1_axi_rready(rready)
    );

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (awready && wready) break; end
        if (n == 50) begin
            checks++; failures++;
            $display("FAIL wr_timeout addr=%h awready=%b required 1", a, awready);
            awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx; return;
        end
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (bvalid) break; end
        if (n == 50) begin
            checks++; failures++;
            $display("FAIL b_timeout addr=%h bvalid=0 required 1", a);
            resp = 2'bxx; return;
        end
        resp = bresp;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (arready) break; end
        if (n == 50) begin
            checks++; failures++;
            $display("FAIL ar_timeout addr=%h arready=0 required 1", a);
            arvalid = 1'b0; d = 'x; resp = 2'bxx; return;
        end
        @(posedge clk); #1 arvalid = 1'b0;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (rvalid) break; end
        if (n == 50) begin
            checks++; failures++;
            $display("FAIL r_timeout addr=%h rvalid=0 required 1", a);
            d = 'x; resp = 2'bxx; return;
        end
        d = rdata; resp = rresp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; exp_t e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got aw=%b w=%b b=%b bresp=%b ar=%b r=%b rdata=%h rresp=%b, need all 0",
                     awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back('{32'h0, 2'b00});
        rd(8'h2C, d, r);
        e = sb_q.pop_front(); checks++;
        if (d !== e.data || r !== e.resp) begin
            failures++; $display("FAIL reset_result got %h/%b need %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_compute();
        op_t ops[$]; logic [31:0] d; logic [1:0] r; exp_t e;
        ops.push_back('{1'b1, 8'h00, 32'd5, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'h0C, 32'd0, 4'h0, 32'd0, 2'b00});  // operand write alone keeps RESULT
        ops.push_back('{1'b1, 8'h04, 32'd7, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b1, 8'h08, 32'h4, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'h0C, 32'd0, 4'h0, 32'd12, 2'b00});
        ops.push_back('{1'b0, 8'hF0, 32'd0, 4'h0, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'h08, 32'd0, 4'h0, 32'd0, 2'b00});
        foreach (ops[i]) begin
            sb_q.push_back('{ops[i].ed, ops[i].er});
            d = '0;
            if (ops[i].is_wr) wr(ops[i].a, ops[i].d, ops[i].s, r);
            else rd(ops[i].a, d, r);
            e = sb_q.pop_front(); checks++;
            if (r !== e.resp || (!ops[i].is_wr && d !== e.data)) begin
                failures++;
                $display("FAIL compute[%0d] addr=%h got %h/%b need %h/%b", i, ops[i].a, d, r, e.data, e.resp);
            end
        end
    endtask

    task automatic test_carry();
        op_t ops[$]; logic [31:0] d; logic [1:0] r; exp_t e;
        ops.push_back('{1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b1, 8'h14, 32'd2, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b1, 8'h18, 32'h4, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'h1C, 32'd0, 4'h0, 32'd1, 2'b00});
        ops.push_back('{1'b0, 8'hF0, 32'd0, 4'h0, 32'h2, 2'b00});
        ops.push_back('{1'b1, 8'hF0, 32'h2, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'hF0, 32'd0, 4'h0, 32'h0, 2'b00});
        foreach (ops[i]) begin
            sb_q.push_back('{ops[i].ed, ops[i].er});
            d = '0;
            if (ops[i].is_wr) wr(ops[i].a, ops[i].d, ops[i].s, r);
            else rd(ops[i].a, d, r);
            e = sb_q.pop_front(); checks++;
            if (r !== e.resp || (!ops[i].is_wr && d !== e.data)) begin
                failures++;
                $display("FAIL carry[%0d] addr=%h got %h/%b need %h/%b", i, ops[i].a, d, r, e.data, e.resp);
            end
        end
    endtask

    task automatic test_sub_acc();
        op_t ops[$]; logic [31:0] d; logic [1:0] r; exp_t e;
        ops.push_back('{1'b1, 8'h20, 32'd3, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b1, 8'h24, 32'd5, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b1, 8'h28, 32'h5, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'h2C, 32'd0, 4'h0, 32'hFFFF_FFFE, 2'b00});
        ops.push_back('{1'b0, 8'hF0, 32'd0, 4'h0, 32'h4, 2'b00});
        ops.push_back('{1'b1, 8'h20, 32'd4, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b1, 8'h28, 32'h6, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'h2C, 32'd0, 4'h0, 32'd2, 2'b00});
        ops.push_back('{1'b0, 8'h28, 32'd0, 4'h0, 32'h2, 2'b00});
        ops.push_back('{1'b0, 8'hF0, 32'd0, 4'h0, 32'h4, 2'b00});
        foreach (ops[i]) begin
            sb_q.push_back('{ops[i].ed, ops[i].er});
            d = '0;
            if (ops[i].is_wr) wr(ops[i].a, ops[i].d, ops[i].s, r);
            else rd(ops[i].a, d, r);
            e = sb_q.pop_front(); checks++;
            if (r !== e.resp || (!ops[i].is_wr && d !== e.data)) begin
                failures++;
                $display("FAIL sub_acc[%0d] addr=%h got %h/%b need %h/%b", i, ops[i].a, d, r, e.data, e.resp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r; exp_t e; int n;
        wr(8'h34, 32'h33, 4'hF, r);
        // first write held in W_RESP while a second one is already presented
        bready = 1'b0; awaddr = 8'h30; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (awready) break; end
        @(posedge clk); #1 wdata = 32'h22;
        sb_q.push_back('{32'h0, 2'b00});
        e = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || bresp !== e.resp) begin
                failures++;
                $display("FAIL b_hold[%0d] got bvalid=%b awready=%b bresp=%b need 1/0/%b", k, bvalid, awready, bresp, e.resp);
            end
        end
        bready = 1'b1;
        sb_q.push_back('{32'h0, 2'b00});
        wr(8'h30, 32'h22, 4'hF, r);
        e = sb_q.pop_front(); checks++;
        if (r !== e.resp) begin failures++; $display("FAIL b2b_second_bresp got %b need %b", r, e.resp); end

        rready = 1'b0; araddr = 8'h30; arvalid = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (arready) break; end
        @(posedge clk); #1 araddr = 8'h34;
        sb_q.push_back('{32'h22, 2'b00});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); checks++;
            if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== sb_q[0].data || rresp !== sb_q[0].resp) begin
                failures++;
                $display("FAIL r_hold[%0d] got rvalid=%b arready=%b rdata=%h need 1/0/%h", k, rvalid, arready, rdata, sb_q[0].data);
            end
        end
        void'(sb_q.pop_front());
        rready = 1'b1;
        sb_q.push_back('{32'h33, 2'b00});
        rd(8'h34, d, r);
        e = sb_q.pop_front(); checks++;
        if (d !== e.data || r !== e.resp) begin
            failures++; $display("FAIL b2b_second_read got %h/%b need %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_errors();
        op_t ops[$]; logic [31:0] d; logic [1:0] r; exp_t e;
        ops.push_back('{1'b1, 8'h80, 32'hDEAD, 4'hF, 32'd0, 2'b10});
        ops.push_back('{1'b0, 8'h80, 32'd0, 4'h0, 32'd0, 2'b10});
        ops.push_back('{1'b1, 8'h0C, 32'h55, 4'hF, 32'd0, 2'b10});
        ops.push_back('{1'b0, 8'h0C, 32'd0, 4'h0, 32'd12, 2'b00});
        ops.push_back('{1'b0, 8'hE0, 32'd0, 4'h0, 32'd0, 2'b10});
        ops.push_back('{1'b1, 8'hF4, 32'h1234, 4'hF, 32'd0, 2'b10});
        ops.push_back('{1'b0, 8'hF4, 32'd0, 4'h0, 32'hADD2_0004, 2'b00});
        ops.push_back('{1'b0, 8'h0F, 32'd0, 4'h0, 32'd12, 2'b00});
        ops.push_back('{1'b1, 8'h00, 32'h1122_3344, 4'hF, 32'd0, 2'b00});
        ops.push_back('{1'b1, 8'h00, 32'hAABB_CCDD, 4'h1, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'h00, 32'd0, 4'h0, 32'h1122_33DD, 2'b00});
        ops.push_back('{1'b1, 8'hF0, 32'h4, 4'h2, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'hF0, 32'd0, 4'h0, 32'h4, 2'b00});
        ops.push_back('{1'b1, 8'hF0, 32'h4, 4'h1, 32'd0, 2'b00});
        ops.push_back('{1'b0, 8'hF0, 32'd0, 4'h0, 32'h0, 2'b00});
        foreach (ops[i]) begin
            sb_q.push_back('{ops[i].ed, ops[i].er});
            d = '0;
            if (ops[i].is_wr) wr(ops[i].a, ops[i].d, ops[i].s, r);
            else rd(ops[i].a, d, r);
            e = sb_q.pop_front(); checks++;
            if (r !== e.resp || (!ops[i].is_wr && d !== e.data)) begin
                failures++;
                $display("FAIL errors[%0d] addr=%h got %h/%b need %h/%b", i, ops[i].a, d, r, e.data, e.resp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] addrs [9];
        logic [31:0] d; logic [1:0] r; exp_t e; int n;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h1C, 8'h2C, 8'hF0, 8'hF4};
        bready = 1'b0; awaddr = 8'h00; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (awready) break; end
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (bvalid) break; end
        checks++;
        if (bvalid !== 1'b1) begin failures++; $display("FAIL mid_bvalid got %b need 1", bvalid); end
        #2 rst_n = 1'b0;
        #1 checks++;
        if (bvalid !== 1'b0 || awready !== 1'b0 || rvalid !== 1'b0) begin
            failures++; $display("FAIL async_reset got bvalid=%b awready=%b rvalid=%b need 0", bvalid, awready, rvalid);
        end
        @(negedge clk); rst_n = 1'b1; bready = 1'b1;
        repeat (3) begin
            @(negedge clk); checks++;
            if (bvalid !== 1'b0) begin failures++; $display("FAIL stale_bresp got bvalid=%b need 0", bvalid); end
        end
        foreach (addrs[i]) begin
            sb_q.push_back('{(addrs[i] == 8'hF4) ? 32'hADD2_0004 : 32'h0, 2'b00});
            rd(addrs[i], d, r);
            e = sb_q.pop_front(); checks++;
            if (d !== e.data || r !== e.resp) begin
                failures++; $display("FAIL post_reset addr=%h got %h/%b need %h/%b", addrs[i], d, r, e.data, e.resp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_compute();
        test_carry();
        test_sub_acc();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached, summary not printed normally");
        $fatal(1, "timeout");
    end
endmodule
